// File: rtl/uart_rx_controller.sv
// UART receive sequencer: synchronises RxD, qualifies the start bit, samples each bit
// mid-period from the oversampling tick, drives the external shifter and checks parity/stop.
module uart_rx_controller #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 Rx_EN,
    input  logic                 RxD,
    input  logic                 Rx_sample_ENABLE,
    input  logic [DATA_BITS-1:0] Rx_PO,
    output logic                 Rx_SHIFT,
    output logic                 Rx_SI,
    output logic                 Rx_DATA_STATE,
    output logic [DATA_BITS-1:0] Rx_DATA,
    output logic                 Rx_VALID,
    output logic                 Rx_PERROR,
    output logic                 Rx_FERROR
);

    localparam int   CW       = $clog2(OVERSAMPLE);
    localparam int   BW       = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic ACC_INIT = (PARITY_ODD != 0);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW-1:0]         bitcnt_q, bitcnt_d;
    logic                  acc_q, acc_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic                  rx_shift_q, rx_shift_d;
    logic                  rx_si_q, rx_si_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  rx_perror_q, rx_perror_d;
    logic                  rx_ferror_q, rx_ferror_d;
    logic [DATA_BITS-1:0]  rx_data_q, rx_data_d;
    logic                  rxd_meta_q, rxd_s_q;
    logic                  tick;

    assign tick = Rx_sample_ENABLE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
        end else begin
            rxd_meta_q <= RxD;
            rxd_s_q    <= rxd_meta_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bitcnt_d    = bitcnt_q;
        acc_d       = acc_q;
        perr_d      = perr_q;
        ferr_d      = ferr_q;
        rx_shift_d  = 1'b0;
        rx_si_d     = rx_si_q;
        rx_valid_d  = 1'b0;
        rx_perror_d = rx_perror_q;
        rx_ferror_d = rx_ferror_q;
        rx_data_d   = rx_data_q;
        if (!Rx_EN) begin
            // Abort: the registered shift pulse already issued still reaches the shifter.
            state_d  = IDLE;
            cnt_d    = '0;
            bitcnt_d = '0;
            acc_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (tick && !rxd_s_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
                START: if (tick) begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_d = '0;
                        if (!rxd_s_q) begin
                            state_d  = DATA;
                            bitcnt_d = '0;
                            acc_d    = ACC_INIT;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                DATA: if (tick) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CNT_MAX) begin
                        rx_shift_d = 1'b1;
                        rx_si_d    = rxd_s_q;
                        acc_d      = acc_q ^ rxd_s_q;
                        bitcnt_d   = bitcnt_q + BW'(1);
                        if (bitcnt_q == BIT_LAST) begin
                            state_d = (PARITY_EN != 0) ? PARITY : STOP;
                            perr_d  = 1'b0;
                            cnt_d   = '0;
                        end
                    end
                end
                PARITY: if (tick) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CNT_MAX) begin
                        perr_d  = acc_q ^ rxd_s_q;
                        state_d = STOP;
                        cnt_d   = '0;
                    end
                end
                STOP: if (tick) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CNT_MAX) begin
                        ferr_d  = ~rxd_s_q;
                        state_d = DONE;
                        cnt_d   = '0;
                    end
                end
                DONE: begin
                    rx_data_d   = Rx_PO;
                    rx_perror_d = perr_q;
                    rx_ferror_d = ferr_q;
                    rx_valid_d  = ~perr_q & ~ferr_q;
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bitcnt_q    <= '0;
            acc_q       <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            rx_shift_q  <= 1'b0;
            rx_si_q     <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_perror_q <= 1'b0;
            rx_ferror_q <= 1'b0;
            rx_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bitcnt_q    <= bitcnt_d;
            acc_q       <= acc_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            rx_shift_q  <= rx_shift_d;
            rx_si_q     <= rx_si_d;
            rx_valid_q  <= rx_valid_d;
            rx_perror_q <= rx_perror_d;
            rx_ferror_q <= rx_ferror_d;
            rx_data_q   <= rx_data_d;
        end
    end

    assign Rx_SHIFT      = rx_shift_q;
    assign Rx_SI         = rx_si_q;
    assign Rx_VALID      = rx_valid_q;
    assign Rx_PERROR     = rx_perror_q;
    assign Rx_FERROR     = rx_ferror_q;
    assign Rx_DATA       = rx_data_q;
    assign Rx_DATA_STATE = (state_q == DATA);

endmodule
